// File: rtl/datapath_ctrl.sv
// datapath_ctrl: Moore sequencer that walks one 16-bit instruction through
// decode, register read, ALU and write-back by driving the datapath controls.
// Outputs are registered from the next state and next IR, so each control
// is a clean flop output that is valid for the whole cycle of its state.
module datapath_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] instr,
    output logic        w,
    output logic        illegal,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in
);

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WIMM   = 3'd2,
        ST_GETA   = 3'd3,
        ST_GETB   = 3'd4,
        ST_ALU    = 3'd5,
        ST_WBACK  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        K_MOVI = 3'd0,
        K_MOVR = 3'd1,
        K_ADD  = 3'd2,
        K_CMP  = 3'd3,
        K_AND  = 3'd4,
        K_MVN  = 3'd5,
        K_ILL  = 3'd6
    } kind_t;

    typedef struct packed {
        logic        w;
        logic        illegal;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        vsel;
        logic        loada;
        logic        loadb;
        logic        asel;
        logic        bsel;
        logic        loadc;
        logic        loads;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] datapath_in;
    } ctrl_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q;

    // Classify the instruction by its opc/op pair.
    function automatic kind_t decode_kind(input logic [15:0] ir);
        kind_t k;
        case (ir[15:11])
            5'b110_10: k = K_MOVI;
            5'b110_00: k = K_MOVR;
            5'b101_00: k = K_ADD;
            5'b101_01: k = K_CMP;
            5'b101_10: k = K_AND;
            5'b101_11: k = K_MVN;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    // Control word produced while sitting in state st with instruction ir.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] ir);
        ctrl_t c;
        kind_t k;
        c             = '0;
        k             = decode_kind(ir);
        c.datapath_in = {{8{ir[7]}}, ir[7:0]};
        case (st)
            ST_WAIT: begin
                c.w = 1'b1;
            end
            ST_DECODE: begin
                c.illegal = (k == K_ILL);
            end
            ST_WIMM: begin
                c.write    = 1'b1;
                c.vsel     = 1'b1;
                c.writenum = ir[10:8];
            end
            ST_GETA: begin
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
            end
            ST_GETB: begin
                c.readnum = ir[2:0];
                c.loadb   = 1'b1;
            end
            ST_ALU: begin
                c.shift = ir[4:3];
                c.bsel  = 1'b0;
                if (k == K_MOVR) begin
                    // A operand forced to zero so the ALU passes the shifted B
                    c.aluop = 2'b00;
                    c.asel  = 1'b1;
                end else begin
                    c.aluop = ir[12:11];
                    c.asel  = 1'b0;
                end
                if (k == K_CMP) begin
                    c.loads = 1'b1;
                    c.loadc = 1'b0;
                end else begin
                    c.loads = 1'b0;
                    c.loadc = 1'b1;
                end
            end
            ST_WBACK: begin
                c.write    = 1'b1;
                c.vsel     = 1'b0;
                c.writenum = ir[7:5];
            end
            default: begin
                c.w = 1'b0;
            end
        endcase
        return c;
    endfunction

    // Next-state and instruction-capture logic.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_WAIT: begin
                if (s) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DECODE: begin
                case (decode_kind(ir_q))
                    K_MOVI:               state_d = ST_WIMM;
                    K_ADD, K_CMP, K_AND:  state_d = ST_GETA;
                    K_MOVR, K_MVN:        state_d = ST_GETB;
                    default:              state_d = ST_WAIT;
                endcase
            end
            ST_WIMM:  state_d = ST_WAIT;
            ST_GETA:  state_d = ST_GETB;
            ST_GETB:  state_d = ST_ALU;
            ST_ALU: begin
                if (decode_kind(ir_q) == K_CMP) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_WBACK;
                end
            end
            ST_WBACK: state_d = ST_WAIT;
            default:  state_d = ST_WAIT;
        endcase
    end

    // State, IR and registered control outputs; reset returns to an idle WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
            ir_q    <= 16'h0000;
            ctrl_q  <= ctrl_for(ST_WAIT, 16'h0000);
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_for(state_d, ir_d);
        end
    end

    assign w           = ctrl_q.w;
    assign illegal     = ctrl_q.illegal;
    assign readnum     = ctrl_q.readnum;
    assign writenum    = ctrl_q.writenum;
    assign write       = ctrl_q.write;
    assign vsel        = ctrl_q.vsel;
    assign loada       = ctrl_q.loada;
    assign loadb       = ctrl_q.loadb;
    assign asel        = ctrl_q.asel;
    assign bsel        = ctrl_q.bsel;
    assign loadc       = ctrl_q.loadc;
    assign loads       = ctrl_q.loads;
    assign shift       = ctrl_q.shift;
    assign ALUop       = ctrl_q.aluop;
    assign datapath_in = ctrl_q.datapath_in;

endmodule
